// File: rtl/sd_clk_pkg.sv
// rtl/sd_clk_pkg.sv - shared types and defaults for the SD card-clock generator
package sd_clk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2
  } settle_state_e;

  localparam int SD_DIV_W_DEFAULT          = 10;
  localparam int SD_STABLE_PERIODS_DEFAULT = 4;

endpackage

// File: rtl/sd_clk_phase_cnt.sv
// rtl/sd_clk_phase_cnt.sv - phase counter, divisor latch and period boundary detect
module sd_clk_phase_cnt #(
  parameter int DIV_W = 10,
  parameter int CW    = DIV_W + 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             boundary_o,
  output logic [CW-1:0]    cnt_d_o,
  output logic [CW-1:0]    h_d_o,
  output logic [CW-1:0]    p_d_o
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    h_q, p_q;

  assign h_q        = CW'(div_q) + CW'(1);
  assign p_q        = {h_q[CW-2:0], 1'b0};
  assign boundary_o = run_i && (cnt_q == p_q - CW'(1));

  // While the counter is held no clock is produced, so the divisor may track freely.
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (!run_i || boundary_o) begin
      cnt_d = '0;
      div_d = divisor_i;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign cnt_d_o = cnt_d;
  assign h_d_o   = CW'(div_d) + CW'(1);
  assign p_d_o   = {h_d_o[CW-2:0], 1'b0};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/sd_clock_gen.sv
// rtl/sd_clock_gen.sv - glitch-free SD/eMMC card-clock generator with settle FSM
module sd_clock_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W          = SD_DIV_W_DEFAULT,
  parameter int STABLE_PERIODS = SD_STABLE_PERIODS_DEFAULT
) (
  input  logic             AXI_CLOCK,
  input  logic             AXI_RST,
  input  logic [DIV_W-1:0] DIVISOR,
  input  logic             internal_clk_en,
  input  logic             sd_clk_en,
  output logic             sd_clk,
  output logic             sd_clk90,
  output logic             sd_clk_rise,
  output logic             sd_clk_fall,
  output logic             sd_clk_active,
  output logic             Internal_clk_stable
);

  localparam int CW = DIV_W + 2;
  localparam int SW = $clog2(STABLE_PERIODS + 1);

  settle_state_e state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          gate_q, gate_d;
  logic          run, boundary;
  logic [CW-1:0] cnt_d, h_d, p_d, q_d, ph90_d;
  logic          clk_q, clk90_q, rise_q, fall_q;

  assign run = internal_clk_en && (state_q != IDLE);

  sd_clk_phase_cnt #(.DIV_W(DIV_W), .CW(CW)) u_phase (
    .clk_i      (AXI_CLOCK),
    .rst_ni     (AXI_RST),
    .run_i      (run),
    .divisor_i  (DIVISOR),
    .boundary_o (boundary),
    .cnt_d_o    (cnt_d),
    .h_d_o      (h_d),
    .p_d_o      (p_d)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    if (!internal_clk_en) begin
      state_d  = IDLE;
      settle_d = '0;
      gate_d   = 1'b0;
    end else begin
      if (boundary) gate_d = sd_clk_en && (state_q == READY);
      case (state_q)
        IDLE:   state_d = SETTLE;
        SETTLE: begin
          if (boundary) begin
            if (settle_q == SW'(STABLE_PERIODS - 1)) begin
              state_d  = READY;
              settle_d = '0;
            end else begin
              settle_d = settle_q + SW'(1);
            end
          end
        end
        READY:   state_d = READY;
        default: state_d = IDLE;
      endcase
    end
  end

  // Quadrature copy: phase shifted back by floor(H/2), taken modulo the period.
  assign q_d    = h_d >> 1;
  assign ph90_d = (cnt_d >= q_d) ? (cnt_d - q_d) : (cnt_d + p_d - q_d);

  always_ff @(posedge AXI_CLOCK) begin
    if (!AXI_RST) begin
      state_q  <= IDLE;
      settle_q <= '0;
      gate_q   <= 1'b0;
      clk_q    <= 1'b0;
      clk90_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      clk_q    <= gate_d && (cnt_d < h_d);
      clk90_q  <= gate_d && (ph90_d < h_d);
      rise_q   <= gate_d && (cnt_d == '0);
      fall_q   <= gate_d && (cnt_d == h_d);
    end
  end

  assign sd_clk              = clk_q;
  assign sd_clk90            = clk90_q;
  assign sd_clk_rise         = rise_q;
  assign sd_clk_fall         = fall_q;
  assign sd_clk_active       = gate_q;
  assign Internal_clk_stable = (state_q == READY);

endmodule

// File: tb/tb_sd_clock_gen.sv
// tb/tb_sd_clock_gen.sv - self-checking bench for sd_clock_gen against a period-level model
module tb_sd_clock_gen;

  localparam int DW = 10;
  localparam int SP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          sd_en = 1'b0;
  logic [DW-1:0] div = '0;
  logic          sd_clk, sd_clk90, rise, fall, active, stable;

  int tests = 0;
  int fails = 0;

  // Model: position within the current period, latched divisor, gate, whole periods seen.
  int m_pos = 0;
  int m_div = 0;
  int m_gate = 0;
  int m_periods = 0;
  bit m_running = 1'b0;

  always #5 clk = ~clk;

  sd_clock_gen #(.DIV_W(DW), .STABLE_PERIODS(SP)) dut (
    .AXI_CLOCK           (clk),
    .AXI_RST             (rst_n),
    .DIVISOR             (div),
    .internal_clk_en     (en),
    .sd_clk_en           (sd_en),
    .sd_clk              (sd_clk),
    .sd_clk90            (sd_clk90),
    .sd_clk_rise         (rise),
    .sd_clk_fall         (fall),
    .sd_clk_active       (active),
    .Internal_clk_stable (stable)
  );

  function automatic logic [5:0] model_out();
    int h, p, q;
    bit g;
    h = m_div + 1;
    p = 2 * h;
    q = h / 2;
    g = (m_gate != 0);
    return {g && (m_pos < h), g && (((m_pos + p - q) % p) < h),
            g && (m_pos == 0), g && (m_pos == h), g, m_periods >= SP};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_running = 0; m_pos = 0; m_div = 0; m_gate = 0; m_periods = 0;
    end else if (!en) begin
      m_running = 0; m_pos = 0; m_div = int'(div); m_gate = 0; m_periods = 0;
    end else if (!m_running) begin
      m_running = 1; m_pos = 0; m_div = int'(div);
    end else if (m_pos == 2 * (m_div + 1) - 1) begin
      m_gate = (sd_en && (m_periods >= SP)) ? 1 : 0;
      m_periods++;
      m_pos = 0;
      m_div = int'(div);
    end else begin
      m_pos++;
    end
    #1;
    check("outputs", {26'd0, sd_clk, sd_clk90, rise, fall, active, stable}, {26'd0, model_out()});
  endtask

  initial begin
    int n, h, p;
    logic [5:0] v1, v2;

    rst_n = 0;
    tick();
    tick();
    check("reset_outputs", {sd_clk, sd_clk90, rise, fall, active, stable}, 6'b0);

    // Divisor 1: settle time and waveform shape
    rst_n = 1; div = 1; en = 1; sd_en = 1;
    n = 0;
    do begin tick(); n++; end while (!stable && n < 200);
    check("stable_latency_d1", n, 17);
    n = 0;
    while (!rise && n < 20) begin tick(); n++; end
    check("rise_seen_d1", rise, 1);
    v1 = '0; v2 = '0;
    for (int i = 0; i < 4; i++) begin v1[3-i] = sd_clk; v2[3-i] = sd_clk90; tick(); end
    check("sd_clk_d1", v1[3:0], 4'b1100);
    check("sd_clk90_d1", v2[3:0], 4'b0110);
    n = 0;
    for (int i = 0; i < 16; i++) begin if (rise) n++; tick(); end
    check("rise_count_d1", n, 4);

    // Divisor 2
    div = 2;
    n = 0;
    do begin tick(); n++; end while (!(rise && m_div == 2) && n < 40);
    check("rise_seen_d2", rise, 1);
    for (int i = 0; i < 6; i++) begin v1[5-i] = sd_clk; v2[5-i] = sd_clk90; tick(); end
    check("sd_clk_d2", v1, 6'b111000);
    check("sd_clk90_d2", v2, 6'b011100);

    // Divisor change 3 -> 0 at phase 2: current 8-cycle period completes
    div = 3;
    n = 0;
    do begin tick(); n++; end while (!(m_div == 3 && m_pos == 2) && n < 40);
    div = 0;
    n = 0;
    do begin tick(); n++; end while (!rise && n < 20);
    check("period_completes", n, 6);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (sd_clk !== sd_clk90) n++;
      if (i % 2 == 0 && !rise) n++;
      tick();
    end
    check("d0_clk90_eq_and_period2", n, 0);

    // Gate off during a high phase with D = 4
    div = 4;
    n = 0;
    do begin tick(); n++; end while (!(rise && m_div == 4) && n < 40);
    sd_en = 0;
    h = 0;
    while (sd_clk && h < 20) begin h++; tick(); end
    check("last_high_len", h, 5);
    for (int i = 0; i < 5; i++) tick();
    check("gate_closed", {active, sd_clk}, 2'b00);
    n = 0;
    for (int i = 0; i < 20; i++) begin if (sd_clk || sd_clk90 || active) n++; tick(); end
    check("stays_off", n, 0);
    sd_en = 1;
    n = 0;
    while (!rise && n < 30) begin tick(); n++; end
    check("reenable_rise", rise, 1);
    h = 0;
    while (sd_clk && h < 20) begin h++; tick(); end
    check("reenable_high_len", h, 5);

    // Random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 3) div = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 5) sd_en = ~sd_en;
      if ($urandom_range(0, 299) == 0) en = ~en;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    // Internal disable mid-high, then settle restarts
    rst_n = 1; en = 1; sd_en = 1; div = DW'($urandom_range(1, 5));
    n = 0;
    do begin tick(); n++; end while (!(stable && sd_clk) && n < 600);
    check("running_before_disable", sd_clk, 1);
    en = 0;
    tick();
    check("disable_zero", {sd_clk, sd_clk90, rise, fall, active, stable}, 6'b0);
    en = 1;
    p = 2 * (int'(div) + 1);
    n = 0;
    do begin tick(); n++; end while (!stable && n < 300);
    check("resettle_latency", n, 4 * p + 1);

    // Reset mid-period
    n = 0;
    while (!sd_clk && n < 100) begin tick(); n++; end
    rst_n = 0;
    tick();
    check("reset_mid_zero", {sd_clk, sd_clk90, rise, fall, active, stable}, 6'b0);
    rst_n = 1;

    // Maximum divisor
    en = 0;
    tick();
    div = 10'd1023;
    en = 1;
    n = 0;
    do begin tick(); n++; end while (!stable && n < 9000);
    check("stable_latency_max", n, 8193);
    n = 0;
    while (!rise && n < 2100) begin tick(); n++; end
    check("rise_seen_max", rise, 1);
    n = 0;
    while (!sd_clk90 && n < 1000) begin tick(); n++; end
    check("quadrature_max", n, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
